demux1_to_m_hs: RTL and testbench

Registered, handshaked 1-to-M demultiplexer with a per-channel FIFO. It generalises the combinational 1-to-2 demux to M output channels with valid/ready flow control on every port and independent back-pressure per channel. It sits between a single producer, such as a decode or issue stage, and M downstream consumers, such as per-operation posit units. A stalled consumer blocks only traffic addressed to it; traffic for other channels keeps flowing.

---
 rtl/demux1_to_m_hs.sv | 105 ++++++++++
 tb/tb_demux1_to_m_hs.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_to_m_hs.sv
// demux1_to_m_hs
// Registered 1-to-M demultiplexer with valid/ready handshakes and a small
// FIFO per output channel. Back-pressure on one channel only stalls words
// addressed to that channel; the other channels keep flowing.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input word valid
//   in_ready   input word accepted when in_valid & in_ready
//   in_data    input word (N bits)
//   in_sel     destination channel; values >= M are dropped
//   out_valid  bit k: channel k head word valid
//   out_ready  bit k: channel k consumer ready
//   out_data   channel k head word at [k*N +: N]
//   sel_err    one-cycle pulse after an invalid-select word was dropped
module demux1_to_m_hs #(
  parameter int N     = 10,
  parameter int M     = 2,
  parameter int DEPTH = 2,
  parameter int SELW  = $clog2(M)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_data,
  input  logic [SELW-1:0]   in_sel,
  output logic [M-1:0]      out_valid,
  input  logic [M-1:0]      out_ready,
  output logic [M*N-1:0]    out_data,
  output logic              sel_err
);

  localparam int CNTW = $clog2(DEPTH + 1);
  // A single-entry FIFO still needs a one-bit pointer to keep the code uniform.
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]    mem   [M][DEPTH];
  logic [CNTW-1:0] count [M];
  logic [PTRW-1:0] rptr  [M];
  logic [PTRW-1:0] wptr  [M];

  logic [M-1:0] sel_hit;
  logic         sel_ok;
  logic [M-1:0] push;
  logic [M-1:0] pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready looks only at in_sel and registered counts, so there is no
  // path from out_ready or in_valid into it. Out-of-range selects always
  // match no channel and are accepted so they can be dropped.
  always_comb begin
    sel_hit  = '0;
    in_ready = 1'b1;
    for (int k = 0; k < M; k++) begin
      sel_hit[k] = (in_sel == SELW'(k));
      if (sel_hit[k] && (count[k] == CNTW'(DEPTH))) in_ready = 1'b0;
    end
    sel_ok = |sel_hit;
  end

  always_comb begin
    push     = '0;
    pop      = '0;
    out_data = '0;
    for (int k = 0; k < M; k++) begin
      out_valid[k]        = (count[k] != '0);
      pop[k]              = out_valid[k] & out_ready[k];
      push[k]             = in_valid & in_ready & sel_hit[k];
      out_data[k*N +: N]  = mem[k][rptr[k]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
      for (int k = 0; k < M; k++) begin
        count[k] <= '0;
        rptr[k]  <= '0;
        wptr[k]  <= '0;
        for (int d = 0; d < DEPTH; d++) mem[k][d] <= '0;
      end
    end else begin
      sel_err <= in_valid & in_ready & ~sel_ok;
      for (int k = 0; k < M; k++) begin
        if (push[k]) begin
          mem[k][wptr[k]] <= in_data;
          wptr[k]         <= ptr_inc(wptr[k]);
        end
        if (pop[k]) rptr[k] <= ptr_inc(rptr[k]);
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + 1'b1;
          2'b01:   count[k] <= count[k] - 1'b1;
          default: count[k] <= count[k];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux1_to_m_hs.sv
// Bench for demux1_to_m_hs with N=10, M=3, DEPTH=3 (select 3 is invalid,
// depth is not a power of two). A queue-per-channel model is compared to
// the DUT every negative clock edge; directed sequences add literal checks.
module tb_demux1_to_m_hs;

  localparam int N = 10;
  localparam int M = 3;
  localparam int DEPTH = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [1:0]    in_sel;
  logic [M-1:0]  out_valid;
  logic [M-1:0]  out_ready;
  logic [M*N-1:0] out_data;
  logic          sel_err;

  demux1_to_m_hs #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [N-1:0] q [M][$];
  logic [N-1:0] dut_log [M][$];
  logic         exp_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_ready(input logic [1:0] s);
    if (int'(s) >= M) return 1'b1;
    return q[s].size() != DEPTH;
  endfunction

  function automatic logic [M-1:0] model_valid();
    logic [M-1:0] v;
    for (int k = 0; k < M; k++) v[k] = (q[k].size() != 0);
    return v;
  endfunction

  // Model update: acceptance is decided from model state before the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < M; k++) q[k].delete();
      exp_err = 1'b0;
    end else begin
      bit acc;
      acc = in_valid && model_ready(in_sel);
      exp_err = acc && (int'(in_sel) >= M);
      for (int k = 0; k < M; k++)
        if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
      if (acc && int'(in_sel) < M) q[in_sel].push_back(in_data);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(model_valid()));
      for (int k = 0; k < M; k++)
        if (q[k].size() != 0) chk($sformatf("out_data%0d", k), 32'(out_data[k*N +: N]), 32'(q[k][0]));
      chk("in_ready", 32'(in_ready), 32'(model_ready(in_sel)));
      chk("sel_err", 32'(sel_err), 32'(exp_err));
      for (int k = 0; k < M; k++)
        if (out_valid[k] && out_ready[k]) dut_log[k].push_back(out_data[k*N +: N]);
    end
  end

  // Inputs change 2 time units after each rising edge.
  task automatic cyc(input logic v, input logic [1:0] s, input logic [N-1:0] d,
                     input logic [M-1:0] r);
    @(posedge clk);
    #2;
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
    #1;
  endtask

  function automatic logic [N-1:0] ch(input int k);
    return out_data[k*N +: N];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int budget;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    #17 rst_n = 1'b1;
    #1;
    // reset values
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst sel_err", 32'(sel_err), 0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s); #1;
      chk($sformatf("rst in_ready sel%0d", s), 32'(in_ready), 1);
    end

    // routing
    cyc(1, 0, 10'h001, 3'b111);
    cyc(1, 1, 10'h002, 3'b111);
    chk("route v0", 32'(out_valid), 3'b001); chk("route d0", 32'(ch(0)), 10'h001);
    cyc(1, 2, 10'h003, 3'b111);
    chk("route v1", 32'(out_valid), 3'b010); chk("route d1", 32'(ch(1)), 10'h002);
    cyc(0, 0, 10'h000, 3'b111);
    chk("route v2", 32'(out_valid), 3'b100); chk("route d2", 32'(ch(2)), 10'h003);
    cyc(0, 0, 10'h000, 3'b111);
    chk("route idle", 32'(out_valid), 0);

    // back-pressure on channel 2
    cyc(1, 2, 10'h0A1, 3'b011);
    chk("bp ready0", 32'(in_ready), 1);
    cyc(1, 2, 10'h0A2, 3'b011);
    cyc(1, 2, 10'h0A3, 3'b011);
    chk("bp ready2", 32'(in_ready), 1);
    cyc(1, 2, 10'h0A4, 3'b011);
    chk("bp full", 32'(in_ready), 0);
    chk("bp v2", 32'(out_valid[2]), 1);
    cyc(1, 2, 10'h0A5, 3'b011);
    chk("bp still full", 32'(in_ready), 0);
    cyc(1, 1, 10'h0B1, 3'b011);
    chk("bp other ready", 32'(in_ready), 1);
    cyc(0, 0, 10'h000, 3'b011);
    chk("bp ch1 v", 32'(out_valid[1]), 1); chk("bp ch1 d", 32'(ch(1)), 10'h0B1);
    cyc(0, 0, 10'h000, 3'b111);
    chk("bp head A1", 32'(ch(2)), 10'h0A1);
    cyc(0, 0, 10'h000, 3'b111);
    chk("bp head A2", 32'(ch(2)), 10'h0A2);
    cyc(0, 0, 10'h000, 3'b111);
    chk("bp head A3", 32'(ch(2)), 10'h0A3);
    cyc(0, 0, 10'h000, 3'b111);
    chk("bp drained", 32'(out_valid[2]), 0);

    // simultaneous push/pop on channel 0
    cyc(1, 0, 10'h011, 3'b000);
    cyc(0, 0, 10'h000, 3'b000);
    chk("pp head", 32'(ch(0)), 10'h011);
    cyc(1, 0, 10'h012, 3'b001);
    cyc(0, 0, 10'h000, 3'b000);
    chk("pp v", 32'(out_valid[0]), 1); chk("pp advanced", 32'(ch(0)), 10'h012);
    cyc(1, 0, 10'h013, 3'b000);
    cyc(1, 0, 10'h014, 3'b000);
    cyc(1, 0, 10'h015, 3'b001);
    chk("pp full ready", 32'(in_ready), 0);
    cyc(0, 0, 10'h000, 3'b000);
    chk("pp after pop", 32'(ch(0)), 10'h013);
    cyc(0, 0, 10'h000, 3'b001);
    cyc(0, 0, 10'h000, 3'b001);
    chk("pp head 14", 32'(ch(0)), 10'h014);
    cyc(0, 0, 10'h000, 3'b000);
    chk("pp no push", 32'(out_valid[0]), 0);

    // invalid select
    cyc(1, 3, 10'h155, 3'b000);
    chk("inv ready", 32'(in_ready), 1);
    cyc(1, 3, 10'h155, 3'b000);
    chk("inv err", 32'(sel_err), 1); chk("inv no valid", 32'(out_valid), 0);
    cyc(0, 0, 10'h000, 3'b000);
    chk("inv err b2b", 32'(sel_err), 1);
    cyc(0, 0, 10'h000, 3'b000);
    chk("inv err clr", 32'(sel_err), 0);

    // wrap-around stream on channel 1 with random back-pressure
    for (int k = 0; k < M; k++) dut_log[k].delete();
    sent = 0;
    budget = 0;
    while (sent < 20 && budget < 400) begin
      cyc(1, 1, 10'(10'h200 + sent), {1'b0, 1'($urandom_range(1)), 1'b0});
      if (model_ready(2'd1)) sent++;
      budget++;
    end
    if (sent < 20) chk("wrap budget", 32'(sent), 20);
    cyc(0, 0, 10'h000, 3'b111);
    for (int i = 0; i < 5; i++) cyc(0, 0, 10'h000, 3'b111);
    chk("wrap count", 32'(dut_log[1].size()), 20);
    for (int i = 0; i < 20 && i < dut_log[1].size(); i++)
      chk($sformatf("wrap word%0d", i), 32'(dut_log[1][i]), 32'(10'h200 + i));

    // reset mid-operation
    cyc(1, 0, 10'h301, 3'b000);
    cyc(1, 1, 10'h302, 3'b000);
    cyc(1, 2, 10'h303, 3'b000);
    cyc(0, 0, 10'h000, 3'b000);
    chk("pre-rst valid", 32'(out_valid), 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", 32'(out_valid), 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(0, 0, 10'h000, 3'b111);
    chk("post-rst valid", 32'(out_valid), 0);
    chk("post-rst data", 32'(out_data), 0);
    chk("post-rst err", 32'(sel_err), 0);
    chk("post-rst ready", 32'(in_ready), 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
